// File: rtl/tape_xfer_ctrl.sv
// Tape transfer controller: decodes host command/data bytes, streams data nibbles
// into the video_out FIFO with watermark flow control, and reports status bytes.
module tape_xfer_ctrl #(
  parameter int unsigned HI_WM = 450,
  parameter int unsigned LO_WM = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ack,
  output logic [3:0]  vout_fifow_data,
  output logic        vout_fifow_request,
  input  logic [10:0] vout_fifow_used_words,
  output logic [1:0]  xfer_state,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    PAUSED = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [10:0] HiWm = 11'(HI_WM);
  localparam logic [10:0] LoWm = 11'(LO_WM);

  localparam logic [7:0] MsgError  = 8'h45;
  localparam logic [7:0] MsgPause  = 8'h50;
  localparam logic [7:0] MsgResume = 8'h52;
  localparam logic [7:0] MsgDone   = 8'h44;
  localparam logic [7:0] MsgCancel = 8'h43;

  state_t      state_q, state_d;
  logic [15:0] drop_q, drop_d;
  logic        req_q, req_d;
  logic [3:0]  wdata_q, wdata_d;
  logic [7:0]  q0_q, q0_d, q1_q, q1_d;
  logic [1:0]  cnt_q, cnt_d;

  logic       isData, isStartW, isStartR, isCancel, isEnd, isIllegal;
  logic       aboveHi, atOrBelowLo, fifoEmpty;
  logic       wrEn, dropInc, clearDrop, msgValid, popEn;
  logic [7:0] msgByte;

  always_comb begin
    isData    = rx_ready && (rx_data[7:4] == 4'h0);
    isStartW  = rx_ready && (rx_data[7:4] == 4'h1);
    isStartR  = rx_ready && (rx_data[7:4] == 4'h2);
    isCancel  = rx_ready && (rx_data[7:4] == 4'h3);
    isEnd     = rx_ready && (rx_data[7:4] == 4'h4);
    isIllegal = rx_ready && (rx_data[7:4] >= 4'h5);
    aboveHi     = vout_fifow_used_words >= HiWm;
    atOrBelowLo = vout_fifow_used_words <= LoWm;
    fifoEmpty   = vout_fifow_used_words == 11'd0;
  end

  // Command decode and transfer state machine; CANCEL and END_STREAM take
  // precedence over the watermark-driven pause/resume transitions.
  always_comb begin
    state_d   = state_q;
    wrEn      = 1'b0;
    dropInc   = 1'b0;
    clearDrop = 1'b0;
    msgValid  = 1'b0;
    msgByte   = 8'h00;
    case (state_q)
      IDLE: begin
        if (isStartW) begin
          state_d   = WRITE;
          clearDrop = 1'b1;
        end else if (isStartR) begin
          msgValid = 1'b1;
          msgByte  = MsgError;
        end else if (isCancel) begin
          msgValid = 1'b1;
          msgByte  = MsgCancel;
        end
      end
      WRITE: begin
        if (isCancel) begin
          state_d  = IDLE;
          msgValid = 1'b1;
          msgByte  = MsgCancel;
        end else if (isEnd) begin
          state_d = DRAIN;
        end else begin
          if (isData && !aboveHi) wrEn = 1'b1;
          if ((isData && aboveHi) || isIllegal) dropInc = 1'b1;
          if (aboveHi) begin
            state_d  = PAUSED;
            msgValid = 1'b1;
            msgByte  = MsgPause;
          end
        end
      end
      PAUSED: begin
        if (isCancel) begin
          state_d  = IDLE;
          msgValid = 1'b1;
          msgByte  = MsgCancel;
        end else if (isEnd) begin
          state_d = DRAIN;
        end else begin
          if (isData || isIllegal) dropInc = 1'b1;
          if (atOrBelowLo) begin
            state_d  = WRITE;
            msgValid = 1'b1;
            msgByte  = MsgResume;
          end
        end
      end
      DRAIN: begin
        if (isCancel) begin
          state_d  = IDLE;
          msgValid = 1'b1;
          msgByte  = MsgCancel;
        end else begin
          if (isData || isIllegal) dropInc = 1'b1;
          if (fifoEmpty) begin
            state_d  = IDLE;
            msgValid = 1'b1;
            msgByte  = MsgDone;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = wrEn;
    wdata_d = wrEn ? rx_data[3:0] : wdata_q;
    if (clearDrop)
      drop_d = 16'h0000;
    else if (dropInc && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
    else
      drop_d = drop_q;
  end

  // Two-entry status queue; a push into a full queue replaces the newest entry
  // so the head being presented to the host never changes under it.
  always_comb begin
    popEn = tx_ack && (cnt_q != 2'd0);
    q0_d  = q0_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (msgValid) begin
          q0_d  = msgByte;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (popEn && msgValid) begin
          q0_d = msgByte;
        end else if (popEn) begin
          cnt_d = 2'd0;
        end else if (msgValid) begin
          q1_d  = msgByte;
          cnt_d = 2'd2;
        end
      end
      default: begin
        if (popEn) begin
          q0_d = q1_q;
          if (msgValid) q1_d = msgByte;
          else          cnt_d = 2'd1;
        end else if (msgValid) begin
          q1_d = msgByte;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 16'h0000;
      req_q   <= 1'b0;
      wdata_q <= 4'h0;
      q0_q    <= 8'h00;
      q1_q    <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xfer_state         = state_q;
  assign drop_count         = drop_q;
  assign vout_fifow_request = req_q;
  assign vout_fifow_data    = wdata_q;
  assign tx_data            = q0_q;
  assign tx_valid           = cnt_q != 2'd0;
  assign tx_last            = cnt_q != 2'd0;

endmodule
